// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types and ID/EX control bundle
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Control bits carried from ID into EX; ex_mem_stage consumes the same layout.
    typedef struct packed {
        logic   RegWr;
        logic   MemRd;
        logic   MemWr;
        aluop_t aluop;
        logic   alusrc;
        logic   halt;
    } idex_ctrl_t;

    // A bubble must never write a register or touch memory.
    localparam idex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side registered outputs of the ID/EX stage
interface id_ex_if;
    import cpu_types_pkg::*;

    logic     id_valid;
    word_t    id_pc4;
    word_t    id_rdat1;
    word_t    id_rdat2;
    word_t    id_imm;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     id_uses_rt;
    regbits_t id_wsel;
    logic     id_RegWr;
    logic     id_MemRd;
    logic     id_MemWr;
    aluop_t   id_aluop;
    logic     id_alusrc;
    logic     id_halt;

    logic     idex_valid;
    word_t    idex_pc4;
    word_t    idex_rdat1;
    word_t    idex_rdat2;
    word_t    idex_imm;
    regbits_t idex_rs;
    regbits_t idex_rt;
    regbits_t idex_wsel;
    logic     idex_RegWr;
    logic     idex_MemRd;
    logic     idex_MemWr;
    aluop_t   idex_aluop;
    logic     idex_alusrc;
    logic     idex_halt;

    // ID stage / bench side: drives decoded fields, observes the EX copies.
    modport master (
        output id_valid, id_pc4, id_rdat1, id_rdat2, id_imm, id_rs, id_rt, id_uses_rt,
               id_wsel, id_RegWr, id_MemRd, id_MemWr, id_aluop, id_alusrc, id_halt,
        input  idex_valid, idex_pc4, idex_rdat1, idex_rdat2, idex_imm, idex_rs, idex_rt,
               idex_wsel, idex_RegWr, idex_MemRd, idex_MemWr, idex_aluop, idex_alusrc, idex_halt
    );

    // Pipeline register side.
    modport slave (
        input  id_valid, id_pc4, id_rdat1, id_rdat2, id_imm, id_rs, id_rt, id_uses_rt,
               id_wsel, id_RegWr, id_MemRd, id_MemWr, id_aluop, id_alusrc, id_halt,
        output idex_valid, idex_pc4, idex_rdat1, idex_rdat2, idex_imm, idex_rs, idex_rt,
               idex_wsel, idex_RegWr, idex_MemRd, idex_MemWr, idex_aluop, idex_alusrc, idex_halt
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detector
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     i_ex_valid,
    input  logic     i_ex_memrd,
    input  regbits_t i_ex_wsel,
    input  logic     i_id_valid,
    input  regbits_t i_id_rs,
    input  regbits_t i_id_rt,
    input  logic     i_id_uses_rt,
    output logic     o_stall
);
    logic w_rs_hit;
    logic w_rt_hit;

    // $0 is never a real producer, and rt only matters when ID actually reads it.
    always_comb begin
        w_rs_hit = (i_ex_wsel == i_id_rs);
        w_rt_hit = i_id_uses_rt & (i_ex_wsel == i_id_rt);
        o_stall  = i_ex_valid & i_ex_memrd & (i_ex_wsel != 5'd0) & i_id_valid
                 & (w_rs_hit | w_rt_hit);
    end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and counter
module id_ex_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             advance,
    input  logic             flush,
    id_ex_if.slave           bus,
    output logic             stall_id,
    output logic [CNT_W-1:0] lu_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_valid;
    word_t            r_pc4;
    word_t            r_rdat1;
    word_t            r_rdat2;
    word_t            r_imm;
    regbits_t         r_rs;
    regbits_t         r_rt;
    regbits_t         r_wsel;
    idex_ctrl_t       r_ctrl;
    logic [CNT_W-1:0] r_lu_count;

    idex_ctrl_t       w_id_ctrl;
    logic             w_stall;

    // Pack the ID control bits into the shared bundle layout.
    always_comb begin
        w_id_ctrl        = BUBBLE_CTRL;
        w_id_ctrl.RegWr  = bus.id_RegWr;
        w_id_ctrl.MemRd  = bus.id_MemRd;
        w_id_ctrl.MemWr  = bus.id_MemWr;
        w_id_ctrl.aluop  = bus.id_aluop;
        w_id_ctrl.alusrc = bus.id_alusrc;
        w_id_ctrl.halt   = bus.id_halt;
    end

    load_use_detect u_lud (
        .i_ex_valid   (r_valid),
        .i_ex_memrd   (r_ctrl.MemRd),
        .i_ex_wsel    (r_wsel),
        .i_id_valid   (bus.id_valid),
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .i_id_uses_rt (bus.id_uses_rt),
        .o_stall      (w_stall)
    );

    // Pipeline register: flush beats hold, hold beats stall, stall beats normal load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_rdat1 <= '0;
            r_rdat2 <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_wsel  <= '0;
            r_ctrl  <= BUBBLE_CTRL;
        end else if (flush || (advance && w_stall)) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_rdat1 <= '0;
            r_rdat2 <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_wsel  <= '0;
            r_ctrl  <= BUBBLE_CTRL;
        end else if (advance) begin
            r_valid <= bus.id_valid;
            r_pc4   <= bus.id_pc4;
            r_rdat1 <= bus.id_rdat1;
            r_rdat2 <= bus.id_rdat2;
            r_imm   <= bus.id_imm;
            r_rs    <= bus.id_rs;
            r_rt    <= bus.id_rt;
            r_wsel  <= bus.id_wsel;
            r_ctrl  <= w_id_ctrl;
        end
    end

    // Count only stall bubbles that actually land; a flush that overrides one is not a load-use cost.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_lu_count <= '0;
        end else if (!flush && advance && w_stall && (r_lu_count != CNT_MAX)) begin
            r_lu_count <= r_lu_count + CNT_ONE;
        end
    end

    assign stall_id         = w_stall;
    assign lu_count         = r_lu_count;
    assign bus.idex_valid   = r_valid;
    assign bus.idex_pc4     = r_pc4;
    assign bus.idex_rdat1   = r_rdat1;
    assign bus.idex_rdat2   = r_rdat2;
    assign bus.idex_imm     = r_imm;
    assign bus.idex_rs      = r_rs;
    assign bus.idex_rt      = r_rt;
    assign bus.idex_wsel    = r_wsel;
    assign bus.idex_RegWr   = r_ctrl.RegWr;
    assign bus.idex_MemRd   = r_ctrl.MemRd;
    assign bus.idex_MemWr   = r_ctrl.MemWr;
    assign bus.idex_aluop   = r_ctrl.aluop;
    assign bus.idex_alusrc  = r_ctrl.alusrc;
    assign bus.idex_halt    = r_ctrl.halt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       advance;
    logic       flush;
    logic       stall_id;
    logic [3:0] lu_count;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_if bus ();

    id_ex_stage #(.CNT_W(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .advance  (advance),
        .flush    (flush),
        .bus      (bus),
        .stall_id (stall_id),
        .lu_count (lu_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] ws, input logic rw,
                          input logic mr);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_uses_rt = urt;
        bus.id_wsel    = ws;
        bus.id_RegWr   = rw;
        bus.id_MemRd   = mr;
    endtask

    task automatic set_data(input logic [31:0] pc4, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] imm);
        bus.id_pc4   = pc4;
        bus.id_rdat1 = r1;
        bus.id_rdat2 = r2;
        bus.id_imm   = imm;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.idex_valid}, 32'd0);
        chk({tag, "_wsel"},  {27'd0, bus.idex_wsel},  32'd0);
        chk({tag, "_regwr"}, {31'd0, bus.idex_RegWr}, 32'd0);
        chk({tag, "_rs"},    {27'd0, bus.idex_rs},    32'd0);
    endtask

    initial begin
        nRST    = 1'b0;
        advance = 1'b0;
        flush   = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_data(32'd0, 32'd0, 32'd0, 32'd0);
        bus.id_MemWr  = 1'b0;
        bus.id_aluop  = ALU_SLL;
        bus.id_alusrc = 1'b0;
        bus.id_halt   = 1'b0;
        tick();
        nRST    = 1'b1;
        advance = 1'b1;

        // Load something, then reset asynchronously in the middle of the cycle.
        set_id(1'b1, 5'd7, 5'd6, 1'b1, 5'd12, 1'b1, 1'b0);
        set_data(32'h0000_0040, 32'hAA, 32'hBB, 32'hCC);
        bus.id_halt = 1'b1;
        tick();
        chk("preload_rs", {27'd0, bus.idex_rs}, 32'd7);
        chk("preload_halt", {31'd0, bus.idex_halt}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.idex_valid}, 32'd0);
        chk("rst_rs", {27'd0, bus.idex_rs}, 32'd0);
        chk("rst_rdat1", bus.idex_rdat1, 32'd0);
        chk("rst_halt", {31'd0, bus.idex_halt}, 32'd0);
        chk("rst_lu", {28'd0, lu_count}, 32'd0);
        chk("rst_stall", {31'd0, stall_id}, 32'd0);
        tick();
        nRST = 1'b1;
        bus.id_halt = 1'b0;

        // Normal flow.
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
        set_data(32'h0000_0104, 32'h11, 32'h22, 32'h20);
        bus.id_aluop  = ALU_ADD;
        bus.id_alusrc = 1'b1;
        tick();
        chk("nf_rs", {27'd0, bus.idex_rs}, 32'd3);
        chk("nf_rt", {27'd0, bus.idex_rt}, 32'd4);
        chk("nf_wsel", {27'd0, bus.idex_wsel}, 32'd5);
        chk("nf_regwr", {31'd0, bus.idex_RegWr}, 32'd1);
        chk("nf_rdat1", bus.idex_rdat1, 32'h11);
        chk("nf_pc4", bus.idex_pc4, 32'h104);
        chk("nf_aluop", {28'd0, bus.idex_aluop}, 32'd2);
        chk("nf_alusrc", {31'd0, bus.idex_alusrc}, 32'd1);

        // Load-use stall: lw $8 in EX, consumer reads $8 as rs.
        set_id(1'b1, 5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        chk("lw_memrd", {31'd0, bus.idex_MemRd}, 32'd1);
        set_id(1'b1, 5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        chk("lu_stall", {31'd0, stall_id}, 32'd1);
        tick();
        chk_bubble("lu_bub");
        chk("lu_cnt1", {28'd0, lu_count}, 32'd1);
        chk("lu_stall_drop", {31'd0, stall_id}, 32'd0);
        tick();
        chk("lu_cons_valid", {31'd0, bus.idex_valid}, 32'd1);
        chk("lu_cons_rs", {27'd0, bus.idex_rs}, 32'd8);
        chk("lu_cons_wsel", {27'd0, bus.idex_wsel}, 32'd9);

        // Non-hazard: load to $0 with consumer rs=0.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        #1;
        chk("r0_nostall", {31'd0, stall_id}, 32'd0);

        // Load to $9; rt matches only when rt is actually used.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 5'd9, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("rt_unused", {31'd0, stall_id}, 32'd0);
        bus.id_uses_rt = 1'b1;
        #1;
        chk("rt_used", {31'd0, stall_id}, 32'd1);
        bus.id_valid = 1'b0;
        #1;
        chk("idvalid0", {31'd0, stall_id}, 32'd0);

        // Non-load producer of $8 is left to forwarding.
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        chk("nonload", {31'd0, stall_id}, 32'd0);
        chk("nonload_cnt", {28'd0, lu_count}, 32'd1);

        // Hold for three cycles while ID changes.
        advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'(10 + i), 5'(20 + i), 1'b1, 5'(15 + i), 1'b0, 1'b0);
            set_data(32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300));
            tick();
            chk("hold_wsel", {27'd0, bus.idex_wsel}, 32'd8);
            chk("hold_rs", {27'd0, bus.idex_rs}, 32'd1);
            chk("hold_rdat1", bus.idex_rdat1, 32'h11);
        end

        // Flush wins over hold.
        flush = 1'b1;
        tick();
        chk_bubble("fl_hold");
        chk("fl_hold_rdat1", bus.idex_rdat1, 32'd0);
        flush   = 1'b0;
        advance = 1'b1;

        // Flush wins over stall and is not counted.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("fs_stall", {31'd0, stall_id}, 32'd1);
        flush = 1'b1;
        tick();
        chk_bubble("fs_bub");
        chk("fs_cnt", {28'd0, lu_count}, 32'd1);
        flush = 1'b0;

        // Saturation: 17 more load-use bubbles, counter stops at 15.
        for (int i = 0; i < 17; i++) begin
            set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
            tick();
            chk("sat_cnt", {28'd0, lu_count}, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
        end

        // Reset mid-stall drops stall_id immediately.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("rs_stall_pre", {31'd0, stall_id}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rs_stall_post", {31'd0, stall_id}, 32'd0);
        chk("rs_memrd", {31'd0, bus.idex_MemRd}, 32'd0);
        chk("rs_cnt", {28'd0, lu_count}, 32'd0);
        tick();
        nRST = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with built-in load-use hazard detection.
- Latches decoded instruction fields, register-file read data and control from the ID stage.
- Presents them to the EX stage and to the forwarding unit, which consumes idex_rs, idex_rt and idex_wsel.
- Inserts a one-cycle bubble when an EX-stage load feeds the instruction in ID.
- Counts inserted load-use bubbles for performance debug.

Parameters:
- CNT_W, 16, width of the saturating load-use bubble counter.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- advance  in  1  pipeline enable; 0 holds all state (memory stall)
- flush  in  1  branch/jump taken; squash the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_pc4  in  32  PC+4 of ID instruction
- id_rdat1  in  32  register-file read port 1 (rs)
- id_rdat2  in  32  register-file read port 2 (rt)
- id_imm  in  32  extended immediate
- id_rs  in  5  source register 1
- id_rt  in  5  source register 2
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_wsel  in  5  destination register
- id_RegWr  in  1  register write enable
- id_MemRd  in  1  load
- id_MemWr  in  1  store
- id_aluop  in  4  ALU operation
- id_alusrc  in  1  ALU B operand selects immediate
- id_halt  in  1  halt instruction
- idex_valid, idex_pc4, idex_rdat1, idex_rdat2, idex_imm, idex_rs, idex_rt, idex_wsel, idex_RegWr, idex_MemRd, idex_MemWr, idex_aluop, idex_alusrc, idex_halt  out  (same widths)  registered copies
- stall_id  out  1  combinational; hold PC and IF/ID this cycle
- lu_count  out  CNT_W  number of load-use bubbles inserted

Behaviour:
- Reset (nRST=0, asynchronous): all idex_* outputs = 0, lu_count = 0; stall_id follows its combinational equation (0 because idex_MemRd=0).
- Load-use detect (combinational): stall_id = idex_valid & idex_MemRd & (idex_wsel != 0) & id_valid & ((idex_wsel == id_rs) | (id_uses_rt & (idex_wsel == id_rt))). stall_id is independent of advance and flush.
- Update priority on each rising CLK edge:
  1. flush=1: load a bubble regardless of advance.
  2. advance=0: hold every register.
  3. stall_id=1: load a bubble; lu_count increments.
  4. Otherwise: load all id_* fields.
- Bubble contents: idex_valid, idex_RegWr, idex_MemRd, idex_MemWr, idex_halt = 0; idex_wsel = 0; idex_rs = 0; idex_rt = 0. Data fields (pc4, rdat, imm, aluop, alusrc) also cleared to 0 for deterministic traces.
- A bubble never triggers forwarding or writes, because wsel and RegWr are 0.
- Latency: exactly one cycle from ID inputs to idex outputs when advancing. A load-use stall costs exactly one bubble: after the bubble the load sits in EX/MEM, stall_id drops, and the consumer enters EX one cycle later.
- Counter: lu_count increments only on a bubble inserted by case 3. It saturates at all-ones and does not wrap. Flush overriding a stall does not count.
- Simultaneous flush and stall_id: flush wins, since the consumer in ID is squashed upstream anyway.
- Reset mid-stall: state clears immediately, and stall_id deasserts in the same cycle.
- Register $0: a load to $0 never stalls.
- id_valid=0 in ID: never stalls.

Decomposition:
- cpu_types_pkg (shared, existing):
  - word_t (32-bit), regbits_t (5-bit), aluop_t (4-bit enum).
  - New packed struct idex_ctrl_t {RegWr, MemRd, MemWr, aluop, alusrc, halt}, also used by ex_mem_stage.
  - Constant BUBBLE_CTRL = all-zero idex_ctrl_t.
- Sub-module load_use_detect: purely combinational stall_id equation, instantiated once; reusable by a future hazard unit.

Test Plan:
- Reset then normal flow: assert nRST=0 mid-cycle -> all outputs 0 asynchronously. Release; with advance=1, id_rs=3, id_rt=4, id_wsel=5, id_RegWr=1, id_rdat1=0x11 -> next edge idex_rs=3, idex_rt=4, idex_wsel=5, idex_RegWr=1, idex_rdat1=0x11.
- Load-use stall: EX holds lw with idex_wsel=8, idex_MemRd=1; ID has id_rs=8 -> stall_id=1. Next edge idex_valid=0, idex_wsel=0, lu_count=1. Following cycle stall_id=0, and the consumer latches on the next edge.
- Non-hazards:
  - Load to $0 with id_rs=0 -> stall_id=0.
  - idex_wsel=9 with id_rt=9 but id_uses_rt=0 -> stall_id=0.
  - Non-load with RegWr and wsel=8, id_rs=8 -> stall_id=0, handled by forwarding instead.
- Hold and flush:
  - advance=0 for 3 cycles with changing id_* -> idex_* unchanged.
  - flush=1 with advance=0 -> bubble loaded.
  - flush=1 with stall_id=1 -> bubble loaded, lu_count unchanged.
- Saturation: with CNT_W=4, force 17 consecutive load-use bubbles -> lu_count stops at 15 and never wraps to 0.
